// File: rtl/ripple_count_monitor.sv
// ripple_count_monitor: filters a glitchy, unsynchronised ripple-counter value
//   and reports the accepted count, threshold hits, wraps and a wrap tally.
// Latency: a value held on cnt_in_i for two edges is accepted on the third edge.
// Backpressure: none, the monitor only observes the counter.
// Ports:
//   clock_i, reset_i        clock, asynchronous active-high reset
//   enable_i                monitor enable; low returns the FSM to IDLE
//   cnt_in_i[N:0]           raw ripple-counter value
//   threshold_i[N:0]        compare value for thresh_hit_o
//   cnt_stable_o[N:0]       last accepted count
//   stable_valid_o          cnt_stable_o holds an accepted value
//   thresh_hit_o, wrap_o    single-cycle event pulses on a load
//   wrap_count_o[WRAP_W-1:0] saturating wrap tally
//   seq_err_o               sticky non-increment flag
// Optional feature: define RIPPLE_MON_SEQ_CHECK_EN to build the sequence check
// behind seq_err_o; otherwise seq_err_o is tied low.

module ripple_count_monitor #(
  parameter int N      = 3,
  parameter int WRAP_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [N:0]        cnt_in_i,
  input  logic [N:0]        threshold_i,
  output logic [N:0]        cnt_stable_o,
  output logic              stable_valid_o,
  output logic              thresh_hit_o,
  output logic              wrap_o,
  output logic [WRAP_W-1:0] wrap_count_o,
  output logic              seq_err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACQ   = 2'd1,
    TRACK = 2'd2
  } state_t;

  localparam logic [WRAP_W-1:0] WRAP_MAX = '1;

  state_t            state_q;
  logic [N:0]        s1_q;
  logic [N:0]        s2_q;
  logic [N:0]        cnt_stable_q;
  logic              stable_valid_q;
  logic              thresh_hit_q;
  logic              wrap_q;
  logic [WRAP_W-1:0] wrap_count_q;

  logic              sample_stable;
  logic              track_load;
  logic [WRAP_W-1:0] wrap_count_d;

  // Two-stage sampler. A sample is trusted only once both stages agree,
  // which rejects any value that ripple settling left on the bus for a
  // single edge.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= cnt_in_i;
      s2_q <= s1_q;
    end
  end

  assign sample_stable = (s1_q == s2_q);

  // A load in TRACK happens only for a new, stable value.
  assign track_load = enable_i && (state_q == TRACK) && sample_stable &&
                      (s2_q != cnt_stable_q);

  assign wrap_count_d = (wrap_count_q == WRAP_MAX) ? wrap_count_q
                                                   : wrap_count_q + 1'b1;

  // Control FSM with registered outputs. Pulses default low every edge and
  // are raised only by a TRACK load, so they can never last beyond one cycle
  // unless the next cycle carries another qualifying load.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      cnt_stable_q   <= '0;
      stable_valid_q <= 1'b0;
      thresh_hit_q   <= 1'b0;
      wrap_q         <= 1'b0;
      wrap_count_q   <= '0;
    end else begin
      thresh_hit_q <= 1'b0;
      wrap_q       <= 1'b0;
      if (!enable_i) begin
        // cnt_stable_q deliberately keeps its last value.
        state_q        <= IDLE;
        stable_valid_q <= 1'b0;
        wrap_count_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q        <= ACQ;
            stable_valid_q <= 1'b0;
            wrap_count_q   <= '0;
          end
          ACQ: begin
            // First accepted value is a reference only: no events.
            if (sample_stable) begin
              cnt_stable_q   <= s2_q;
              stable_valid_q <= 1'b1;
              state_q        <= TRACK;
            end
          end
          TRACK: begin
            if (track_load) begin
              cnt_stable_q <= s2_q;
              thresh_hit_q <= (s2_q == threshold_i);
              if (s2_q < cnt_stable_q) begin
                wrap_q       <= 1'b1;
                wrap_count_q <= wrap_count_d;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef RIPPLE_MON_SEQ_CHECK_EN
  logic       seq_err_q;
  logic [N:0] step_d;

  // Modular distance between the new and previous accepted values; a
  // well-behaved counter advances by exactly one per accepted load.
  assign step_d = s2_q - cnt_stable_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      seq_err_q <= 1'b0;
    end else if (!enable_i || (state_q == IDLE)) begin
      seq_err_q <= 1'b0;
    end else if (track_load && (step_d != {{N{1'b0}}, 1'b1})) begin
      seq_err_q <= 1'b1;
    end
  end

  assign seq_err_o = seq_err_q;
`else
  assign seq_err_o = 1'b0;
`endif

  assign cnt_stable_o   = cnt_stable_q;
  assign stable_valid_o = stable_valid_q;
  assign thresh_hit_o   = thresh_hit_q;
  assign wrap_o         = wrap_q;
  assign wrap_count_o   = wrap_count_q;

endmodule

// File: doc/ripple_count_monitor.md
RIPPLE_COUNT_MONITOR -- requirements
Module: ripple_count_monitor

Interface
REQ-001: Parameter N, default 3, monitored count width is N+1 bits (matches the upstream ripple counter output q[N:0]).
REQ-002: Parameter WRAP_W, default 8, width of the wrap accumulator.
REQ-003: clock  input  1  single system clock; all state changes on its rising edge.
REQ-004: reset  input  1  asynchronous, active-high reset.
REQ-005: cnt_in  input  N+1  raw ripple-counter value, unsynchronised, may glitch during ripple settling.
REQ-006: enable  input  1  monitor enable; low forces IDLE.
REQ-007: threshold  input  N+1  compare value, treated as quasi-static.
REQ-008: cnt_stable  output  N+1  last accepted (filtered) count value.
REQ-009: stable_valid  output  1  high once cnt_stable holds an accepted value.
REQ-010: thresh_hit  output  1  one-cycle pulse when an accepted value equals threshold.
REQ-011: wrap  output  1  one-cycle pulse when an accepted value is numerically below the previous accepted value.
REQ-012: wrap_count  output  WRAP_W  number of wraps since reset/enable, saturating.
REQ-013: seq_err  output  1  sticky sequence-error flag (present only per REQ-030).

Function
REQ-014: Input stage SHALL register cnt_in into s1 then s1 into s2 every clock (two-stage sampler, reset to 0).
REQ-015: A sample SHALL be "stable" when s1 == s2; a value held on cnt_in across edges E and E+1 is evaluated at edge E+2 (latency 2 clocks to cnt_stable).
REQ-016: Unstable samples (s1 != s2) SHALL be ignored; no output changes.
REQ-017: FSM states IDLE, ACQ, TRACK; reset state IDLE.
REQ-018: IDLE: enable=1 -> ACQ at next edge; stable_valid=0, wrap_count held at 0, seq_err cleared.
REQ-019: ACQ: first stable sample loads cnt_stable, sets stable_valid, -> TRACK; no wrap, no thresh_hit, no seq_err on this load.
REQ-020: TRACK: stable sample V != cnt_stable SHALL load cnt_stable<=V in the same edge; V == cnt_stable SHALL cause no action.
REQ-021: TRACK: on load, thresh_hit=1 for exactly one cycle if V == threshold.
REQ-022: TRACK: on load, wrap=1 for exactly one cycle if V < old cnt_stable (unsigned); wrap_count increments, saturating at 2^WRAP_W-1.
REQ-023: enable=0 in any state SHALL force IDLE at next edge, clear stable_valid, wrap_count, seq_err, and pulses; cnt_stable holds its value.
REQ-024: Pulses SHALL never be asserted outside TRACK and SHALL be low in the cycle after assertion unless a new load qualifies.
REQ-025: threshold change SHALL only affect subsequent loads; no retroactive pulse.
REQ-026: Full-scale wrap (2^(N+1)-1 -> 0) SHALL assert wrap; a load V==threshold that is also a wrap SHALL assert both pulses together.

Reset
REQ-027: reset=1 SHALL asynchronously set s1, s2, cnt_stable, wrap_count to 0, stable_valid, thresh_hit, wrap, seq_err to 0, FSM to IDLE.
REQ-028: Reset asserted mid-TRACK SHALL discard in-flight samples; after release, operation restarts from IDLE with full 2-clock sampler latency.
REQ-029: Reset SHALL be released synchronously by the integrator; the block adds no reset synchroniser.

Configuration
REQ-030: Macro RIPPLE_MON_SEQ_CHECK_EN defined: in TRACK, a load with (V - old cnt_stable) mod 2^(N+1) != 1 SHALL set seq_err (sticky until reset or enable=0); undefined: seq_err port SHALL tie to 0 and no check logic is built.

Verification
REQ-031: reset, enable=1, cnt_in held 5 for 4 clocks -> cnt_stable=5, stable_valid=1 at edge 3 after enable sampled; no pulses.
REQ-032: TRACK at 14, cnt_in 15 then 0 (N=3) each held 3 clocks -> wrap pulse once on load of 0, wrap_count=1.
REQ-033: threshold=7, cnt_in glitches 6->4->7 with 4 present for 1 clock only -> 4 never loaded, thresh_hit single pulse on load of 7.
REQ-034: WRAP_W=2, drive 5 full wraps -> wrap_count saturates at 3, wrap still pulses each time.
REQ-035: with RIPPLE_MON_SEQ_CHECK_EN, TRACK at 3, cnt_in jumps to 6 -> seq_err=1 and stays; enable=0 one clock -> seq_err=0; without macro seq_err stays 0.
REQ-036: reset pulsed while TRACK at 9 -> all outputs 0 immediately, FSM IDLE, cnt_stable 0.
